// File: rtl/control_pkg.sv
// Shared control-path types: ALU opcodes plus request/response records for the
// shared-ALU arbiter.
package control_pkg;

  localparam int ALU_W           = 32;
  localparam int ALU_ARB_NUM_REQ = 2;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_e          op;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] q;
    logic             zero;
    logic             neg;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: wrapping arithmetic, shifts by b[4:0], Zero/Neg/Overflow flags.
module alu
  import control_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_e          op,
  output logic [ALU_W-1:0] q,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  always_comb begin
    q   = '0;
    ovf = 1'b0;
    case (op)
      ALU_ADD: begin
        q   = a + b;
        ovf = (a[ALU_W-1] == b[ALU_W-1]) && (q[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SUB: begin
        q   = a - b;
        ovf = (a[ALU_W-1] != b[ALU_W-1]) && (q[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_AND:  q = a & b;
      ALU_OR:   q = a | b;
      ALU_XOR:  q = a ^ b;
      ALU_SLT:  q = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: q = {{(ALU_W-1){1'b0}}, (a < b)};
      ALU_SLL:  q = a << b[4:0];
      ALU_SRL:  q = a >> b[4:0];
      ALU_SRA:  q = $unsigned($signed(a) >>> b[4:0]);
      default:  q = '0;
    endcase
  end

  assign zero = (q == '0);
  assign neg  = q[ALU_W-1];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; prio names the requester favoured on contention
// and is exported so checkers can observe the arbiter state.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] grant,
  output logic       prio
);

  always_comb begin
    grant = elig;
    if (&elig) grant = prio ? 2'b10 : 2'b01;
  end

  // The winner hands priority to the other side; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (rst)           prio <= 1'b0;
    else if (grant[0]) prio <= 1'b1;
    else if (grant[1]) prio <= 1'b0;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU between two requesters with round-robin grant and
// per-requester held response registers. ALU_SHARE_ARB_STATS_EN adds grant/conflict counters.
module alu_share_arb
  import control_pkg::*;
#(
  parameter int NUM_REQ = ALU_ARB_NUM_REQ,
  parameter int DATA_W  = ALU_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic    [NUM_REQ-1:0]           req_valid,
  output logic    [NUM_REQ-1:0]           req_ready,
  input  logic    [NUM_REQ-1:0][DATA_W-1:0] req_a,
  input  logic    [NUM_REQ-1:0][DATA_W-1:0] req_b,
  input  alu_op_e [NUM_REQ-1:0]           req_op,
  output logic    [NUM_REQ-1:0]           rsp_valid,
  input  logic    [NUM_REQ-1:0]           rsp_ready,
  output logic    [NUM_REQ-1:0][DATA_W-1:0] rsp_q,
  output logic    [NUM_REQ-1:0]           rsp_zero,
  output logic    [NUM_REQ-1:0]           rsp_neg,
  output logic    [NUM_REQ-1:0][15:0]     stat_grants,
  output logic    [15:0]                  stat_conflicts
);

  if (NUM_REQ != 2) begin : g_bad_num_req
    $error("alu_share_arb: NUM_REQ must be 2");
  end
  if (DATA_W != ALU_W) begin : g_bad_data_w
    $error("alu_share_arb: DATA_W must equal the ALU width");
  end

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid and payload stay put until then, and ready never depends on payload.
  logic [1:0]                   elig;
  logic [1:0]                   grant;
  logic                         dbg_prio;
  alu_req_t                     alu_in;
  alu_rsp_t                     alu_out;
  logic                         alu_ovf;
  logic                         unused_ovf;
  alu_rsp_t [NUM_REQ-1:0]       rsp_r;

  assign elig      = req_valid & (~rsp_valid | rsp_ready);
  assign req_ready = grant;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .elig  (elig),
    .grant (grant),
    .prio  (dbg_prio)
  );

  always_comb begin
    alu_in = '{a: '0, b: '0, op: ALU_ADD};
    if (grant[1])      alu_in = '{a: req_a[1], b: req_b[1], op: req_op[1]};
    else if (grant[0]) alu_in = '{a: req_a[0], b: req_b[0], op: req_op[0]};
  end

  alu u_alu (
    .a    (alu_in.a),
    .b    (alu_in.b),
    .op   (alu_in.op),
    .q    (alu_out.q),
    .zero (alu_out.zero),
    .neg  (alu_out.neg),
    .ovf  (alu_ovf)
  );
  assign unused_ovf = alu_ovf;

  // A grant outranks the drain so a slot refilled while draining never bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_r     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_r[i]     <= alu_out;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_q[i]    = rsp_r[i].q;
    assign rsp_zero[i] = rsp_r[i].zero;
    assign rsp_neg[i]  = rsp_r[i].neg;
  end

`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && stat_grants[i] != 16'hFFFF) stat_grants[i] <= stat_grants[i] + 16'd1;
      end
      if ((&elig) && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`else
  assign stat_grants    = '0;
  assign stat_conflicts = '0;
`endif

`ifndef SYNTHESIS
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      req_valid[i] && !req_ready[i] |=> req_valid[i] && $stable(req_a[i]) &&
                                         $stable(req_b[i]) && $stable(req_op[i]));
  end
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_grant_prio:   assert property (@(posedge clk) disable iff (rst) (&elig) |-> grant[dbg_prio]);
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table plus reset-mid-op and counter sequences.
module tb_alu_share_arb;
  import control_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic    [1:0]        req_valid;
  logic    [1:0]        req_ready;
  logic    [1:0][31:0]  req_a;
  logic    [1:0][31:0]  req_b;
  alu_op_e [1:0]        req_op;
  logic    [1:0]        rsp_valid;
  logic    [1:0]        rsp_ready;
  logic    [1:0][31:0]  rsp_q;
  logic    [1:0]        rsp_zero;
  logic    [1:0]        rsp_neg;
  logic    [1:0][15:0]  stat_grants;
  logic    [15:0]       stat_conflicts;

  int n_total = 0;
  int n_pass  = 0;

  alu_share_arb dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_op         (req_op),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_q          (rsp_q),
    .rsp_zero       (rsp_zero),
    .rsp_neg        (rsp_neg),
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rr;
    alu_op_e     op0;
    logic [31:0] a0;
    logic [31:0] b0;
    alu_op_e     op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  e_ready;
    logic [1:0]  e_rv;
    logic [31:0] e_q0;
    logic [31:0] e_q1;
    logic [1:0]  e_z;
    logic [1:0]  e_n;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] rr,
                              alu_op_e op0, logic [31:0] a0, logic [31:0] b0,
                              alu_op_e op1, logic [31:0] a1, logic [31:0] b1,
                              logic [1:0] er, logic [1:0] erv,
                              logic [31:0] q0, logic [31:0] q1,
                              logic [1:0] z, logic [1:0] n);
    vec_t r;
    r.v = v; r.rr = rr;
    r.op0 = op0; r.a0 = a0; r.b0 = b0;
    r.op1 = op1; r.a1 = a1; r.b1 = b1;
    r.e_ready = er; r.e_rv = erv;
    r.e_q0 = q0; r.e_q1 = q1; r.e_z = z; r.e_n = n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] rr,
                       input alu_op_e op0, input logic [31:0] a0, input logic [31:0] b0,
                       input alu_op_e op1, input logic [31:0] a1, input logic [31:0] b1);
    req_valid = v;  rsp_ready = rr;
    req_op[0] = op0; req_a[0] = a0; req_b[0] = b0;
    req_op[1] = op1; req_a[1] = a1; req_b[1] = b1;
  endtask

  initial begin
    int exp_g;
    int exp_c;
    tbl[0]  = mk(2'b01, 2'b11, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0,
                 2'b01, 2'b01, 32'd12, 32'd0, 2'b00, 2'b00);
    tbl[1]  = mk(2'b10, 2'b11, ALU_ADD, 32'd0, 32'd0, ALU_OR, 32'hF0, 32'h0F,
                 2'b10, 2'b10, 32'd12, 32'hFF, 2'b00, 2'b00);
    tbl[2]  = mk(2'b11, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1,
                 2'b01, 2'b01, 32'd0, 32'hFF, 2'b01, 2'b00);
    tbl[3]  = mk(2'b11, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1,
                 2'b10, 2'b10, 32'd0, 32'd1, 2'b01, 2'b00);
    tbl[4]  = mk(2'b11, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1,
                 2'b01, 2'b01, 32'd0, 32'd1, 2'b01, 2'b00);
    tbl[5]  = mk(2'b11, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1,
                 2'b10, 2'b10, 32'd0, 32'd1, 2'b01, 2'b00);
    tbl[6]  = mk(2'b11, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1,
                 2'b01, 2'b01, 32'd0, 32'd1, 2'b01, 2'b00);
    tbl[7]  = mk(2'b10, 2'b11, ALU_ADD, 32'd0, 32'd0, ALU_SLT, 32'hFFFF_FFFF, 32'd1,
                 2'b10, 2'b10, 32'd0, 32'd1, 2'b01, 2'b00);
    tbl[8]  = mk(2'b10, 2'b11, ALU_ADD, 32'd0, 32'd0, ALU_SRA, 32'h8000_0000, 32'd4,
                 2'b10, 2'b10, 32'd0, 32'hF800_0000, 2'b01, 2'b10);
    tbl[9]  = mk(2'b11, 2'b01, ALU_AND, 32'hFF, 32'h0F, ALU_ADD, 32'd1, 32'd1,
                 2'b01, 2'b11, 32'h0F, 32'hF800_0000, 2'b00, 2'b10);
    tbl[10] = mk(2'b11, 2'b01, ALU_OR, 32'h100, 32'h1, ALU_ADD, 32'd1, 32'd1,
                 2'b01, 2'b11, 32'h101, 32'hF800_0000, 2'b00, 2'b10);
    tbl[11] = mk(2'b11, 2'b01, ALU_SLL, 32'd1, 32'd31, ALU_ADD, 32'd1, 32'd1,
                 2'b01, 2'b11, 32'h8000_0000, 32'hF800_0000, 2'b00, 2'b11);
    tbl[12] = mk(2'b11, 2'b01, ALU_SRL, 32'h8000_0000, 32'd31, ALU_ADD, 32'd1, 32'd1,
                 2'b01, 2'b11, 32'd1, 32'hF800_0000, 2'b00, 2'b10);
    tbl[13] = mk(2'b11, 2'b01, ALU_SUB, 32'd0, 32'd1, ALU_ADD, 32'd1, 32'd1,
                 2'b01, 2'b11, 32'hFFFF_FFFF, 32'hF800_0000, 2'b00, 2'b11);
    tbl[14] = mk(2'b10, 2'b11, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd1, 32'd1,
                 2'b10, 2'b10, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b01);
    tbl[15] = mk(2'b01, 2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd1, 32'd1,
                 2'b01, 2'b11, 32'd0, 32'd2, 2'b01, 2'b00);
    tbl[16] = mk(2'b01, 2'b01, ALU_XOR, 32'hFF, 32'h0F, ALU_ADD, 32'd1, 32'd1,
                 2'b01, 2'b11, 32'hF0, 32'd2, 2'b00, 2'b00);
    tbl[17] = mk(2'b00, 2'b11, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd1, 32'd1,
                 2'b00, 2'b00, 32'hF0, 32'd2, 2'b00, 2'b00);

    // Reset and idle state
    rst = 1'b1;
    drive(2'b00, 2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_q0", rsp_q[0], 32'd0);
    chk("rst_q1", rsp_q[1], 32'd0);
    chk("rst_flags", {28'd0, rsp_zero, rsp_neg}, 32'd0);
    chk("rst_stat_g0", 32'(stat_grants[0]), 32'd0);
    chk("rst_stat_g1", 32'(stat_grants[1]), 32'd0);
    chk("rst_stat_c", 32'(stat_conflicts), 32'd0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].rr, tbl[i].op0, tbl[i].a0, tbl[i].b0,
            tbl[i].op1, tbl[i].a1, tbl[i].b1);
      #1;
      chk($sformatf("r%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      tick();
      chk($sformatf("r%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("r%0d_q0", i), rsp_q[0], tbl[i].e_q0);
      chk($sformatf("r%0d_q1", i), rsp_q[1], tbl[i].e_q1);
      chk($sformatf("r%0d_zero", i), 32'(rsp_zero), 32'(tbl[i].e_z));
      chk($sformatf("r%0d_neg", i), 32'(rsp_neg), 32'(tbl[i].e_n));
    end

    // Reset the cycle after a req1 handshake; a req0 request offered during reset is dropped
    drive(2'b10, 2'b11, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd2, 32'd3);
    #1;
    chk("mid_req_ready", 32'(req_ready), 32'b10);
    tick();
    chk("mid_rsp_valid_pre", 32'(rsp_valid), 32'b10);
    chk("mid_q1_pre", rsp_q[1], 32'd5);
    rst = 1'b1;
    drive(2'b01, 2'b00, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    chk("mid_rsp_valid_post", 32'(rsp_valid), 32'd0);
    chk("mid_q0_post", rsp_q[0], 32'd0);
    chk("mid_q1_post", rsp_q[1], 32'd0);

    // Ten contended cycles straight out of reset: req0 first, then strict alternation
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
      #1;
      chk($sformatf("alt%0d_req_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
      tick();
      chk($sformatf("alt%0d_rsp_valid", k), 32'(rsp_valid), (k % 2 == 0) ? 32'b01 : 32'b10);
      if (k % 2 == 0) chk($sformatf("alt%0d_q0z", k), {rsp_q[0][30:0], rsp_zero[0]}, 32'd1);
      else            chk($sformatf("alt%0d_q1", k), rsp_q[1], 32'd1);
    end
`ifdef ALU_SHARE_ARB_STATS_EN
    exp_g = 5;
    exp_c = 10;
`else
    exp_g = 0;
    exp_c = 0;
`endif
    chk("stat_g0", 32'(stat_grants[0]), 32'(exp_g));
    chk("stat_g1", 32'(stat_grants[1]), 32'(exp_g));
    chk("stat_c", 32'(stat_conflicts), 32'(exp_c));

    // Let the pending req0 complete, then go idle
    drive(2'b01, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk("tail_req_ready", 32'(req_ready), 32'b01);
    tick();
    drive(2'b00, 2'b11, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
    tick();
    chk("tail_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
